// File: rtl/mux_sel_scheduler_if.sv
// Handshake and bus bundle between the mux select scheduler and its
// requesters, the external 32:1 mux and the downstream consumer.
interface mux_sel_scheduler_if;
    logic        enable;
    logic [30:0] req;
    logic [1:0]  mux_out;
    logic        out_ready;
    logic [4:0]  sel;
    logic [30:0] grant;
    logic        out_valid;
    logic [1:0]  out_data;
    logic        busy;

    modport master (
        output enable, req, mux_out, out_ready,
        input  sel, grant, out_valid, out_data, busy
    );

    modport slave (
        input  enable, req, mux_out, out_ready,
        output sel, grant, out_valid, out_data, busy
    );
endinterface

// File: rtl/mux_sel_scheduler.sv
// Round-robin scheduler that steers an external 32:1 mux, waits for the
// select to settle, captures the mux output and hands it downstream.
module mux_sel_scheduler #(
    parameter int SETTLE_CYCLES = 1
) (
    input logic                 clk,
    input logic                 rst_n,
    mux_sel_scheduler_if.slave  bus
);

    localparam logic [3:0] LP_CNT = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        VALID
    } state_t;

    state_t      r_state;
    logic [4:0]  r_sel;
    logic [4:0]  r_last;
    logic [30:0] r_grant;
    logic        r_valid;
    logic [1:0]  r_data;
    logic [3:0]  r_cnt;

    logic [31:0] w_req32;
    logic [4:0]  w_start;
    logic [5:0]  w_idx;
    logic [4:0]  w_win;
    logic        w_found;
    logic        w_any;

    assign w_req32 = {1'b0, bus.req};
    assign w_any   = |bus.req;

    // Pick the first requester at or above last+1, wrapping 30 -> 0.
    always_comb begin
        w_win   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        w_start = (r_last >= 5'd30) ? 5'd0 : r_last + 5'd1;
        for (int i = 0; i < 31; i++) begin
            w_idx = {1'b0, w_start} + 6'(i);
            if (w_idx >= 6'd31)
                w_idx = w_idx - 6'd31;
            if (!w_found && w_req32[w_idx[4:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[4:0];
            end
        end
    end

    // Transaction FSM: grant, settle, capture, hold until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sel   <= '0;
            r_last  <= 5'd30;
            r_grant <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_grant <= '0;
                    if (bus.enable && w_any) begin
                        r_sel   <= w_win;
                        r_grant <= 31'd1 << w_win;
                        r_cnt   <= LP_CNT;
                        r_state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_data  <= bus.mux_out;
                        r_valid <= 1'b1;
                        r_state <= VALID;
                    end
                end
                VALID: begin
                    if (bus.out_ready) begin
                        r_valid <= 1'b0;
                        r_grant <= '0;
                        r_last  <= r_sel;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.sel       = r_sel;
    assign bus.grant     = r_grant;
    assign bus.out_valid = r_valid;
    assign bus.out_data  = r_data;
    assign bus.busy      = (r_state != IDLE);

endmodule

// File: tb/tb_mux_sel_scheduler.sv
// Directed bench for mux_sel_scheduler: default settle instance plus a
// SETTLE_CYCLES=4 instance sharing clock and reset.
module tb_mux_sel_scheduler;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;

    mux_sel_scheduler_if a_if ();
    mux_sel_scheduler_if b_if ();

    mux_sel_scheduler #(.SETTLE_CYCLES(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (a_if)
    );

    mux_sel_scheduler #(.SETTLE_CYCLES(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction on dut1 with out_ready high.
    task automatic txn(input int exp_sel);
        logic [31:0] g;
        g = 32'd1 << exp_sel;
        tick();
        check("txn_sel", 32'(a_if.sel), 32'(exp_sel));
        check("txn_grant", 32'(a_if.grant), g);
        tick();
        check("txn_valid", 32'(a_if.out_valid), 32'd1);
        tick();
        check("txn_done", 32'(a_if.out_valid), 32'd0);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        a_if.enable = 1'b0;
        a_if.req = '0;
        a_if.mux_out = '0;
        a_if.out_ready = 1'b0;
        b_if.enable = 1'b0;
        b_if.req = '0;
        b_if.mux_out = '0;
        b_if.out_ready = 1'b0;

        // reset state
        #2;
        check("rst_sel", 32'(a_if.sel), 32'd0);
        check("rst_grant", 32'(a_if.grant), 32'd0);
        check("rst_valid", 32'(a_if.out_valid), 32'd0);
        check("rst_data", 32'(a_if.out_data), 32'd0);
        check("rst_busy", 32'(a_if.busy), 32'd0);

        // single request, first edge after release starts it
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        a_if.req = 31'h1;
        a_if.enable = 1'b1;
        a_if.out_ready = 1'b1;
        a_if.mux_out = 2'b10;
        tick();
        check("s1_sel", 32'(a_if.sel), 32'd0);
        check("s1_grant", 32'(a_if.grant), 32'h1);
        check("s1_busy", 32'(a_if.busy), 32'd1);
        check("s1_nvalid", 32'(a_if.out_valid), 32'd0);
        a_if.enable = 1'b0;
        tick();
        check("s1_valid", 32'(a_if.out_valid), 32'd1);
        check("s1_data", 32'(a_if.out_data), 32'd2);
        tick();
        check("s1_clr", 32'(a_if.out_valid), 32'd0);
        check("s1_gclr", 32'(a_if.grant), 32'd0);
        check("s1_idle", 32'(a_if.busy), 32'd0);

        // full round robin from reset
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        a_if.req = 31'h7FFF_FFFF;
        a_if.enable = 1'b1;
        for (int t = 0; t < 32; t++)
            txn(t % 31);

        // bits 5 and 20 with last=0 -> 5, 20, 5
        a_if.req = (31'd1 << 5) | (31'd1 << 20);
        txn(5);
        txn(20);
        txn(5);

        // stall in VALID while mux_out toggles
        a_if.req = 31'd1 << 3;
        a_if.out_ready = 1'b0;
        a_if.mux_out = 2'b01;
        tick();
        check("st_sel", 32'(a_if.sel), 32'd3);
        a_if.enable = 1'b0;
        tick();
        check("st_valid", 32'(a_if.out_valid), 32'd1);
        check("st_data", 32'(a_if.out_data), 32'd1);
        for (int i = 0; i < 10; i++) begin
            a_if.mux_out = (i % 2 == 0) ? 2'b10 : 2'b11;
            tick();
            check("st_hold_v", 32'(a_if.out_valid), 32'd1);
            check("st_hold_d", 32'(a_if.out_data), 32'd1);
        end
        a_if.out_ready = 1'b1;
        tick();
        check("st_done", 32'(a_if.out_valid), 32'd0);
        check("st_gclr", 32'(a_if.grant), 32'd0);
        check("st_idle", 32'(a_if.busy), 32'd0);
        check("st_selkeep", 32'(a_if.sel), 32'd3);

        // single requester re-granted
        a_if.enable = 1'b1;
        txn(3);
        txn(3);
        a_if.enable = 1'b0;

        // async reset during VALID
        a_if.req = (31'd1 << 2) | (31'd1 << 12);
        a_if.enable = 1'b1;
        a_if.out_ready = 1'b0;
        tick();
        check("ar_sel", 32'(a_if.sel), 32'd12);
        a_if.enable = 1'b0;
        tick();
        check("ar_valid", 32'(a_if.out_valid), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("ar_v0", 32'(a_if.out_valid), 32'd0);
        check("ar_g0", 32'(a_if.grant), 32'd0);
        check("ar_s0", 32'(a_if.sel), 32'd0);
        check("ar_b0", 32'(a_if.busy), 32'd0);
        tick();
        rst_n = 1'b1;
        a_if.enable = 1'b1;
        a_if.out_ready = 1'b1;
        txn(2);
        a_if.enable = 1'b0;

        // SETTLE_CYCLES=4 with request dropped during settle
        b_if.req = 31'd1 << 9;
        b_if.enable = 1'b1;
        b_if.out_ready = 1'b1;
        b_if.mux_out = 2'b11;
        tick();
        check("s4_sel", 32'(b_if.sel), 32'd9);
        check("s4_grant", 32'(b_if.grant), 32'd1 << 9);
        b_if.req = '0;
        b_if.enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("s4_wait", 32'(b_if.out_valid), 32'd0);
            check("s4_busy", 32'(b_if.busy), 32'd1);
        end
        tick();
        check("s4_valid", 32'(b_if.out_valid), 32'd1);
        check("s4_data", 32'(b_if.out_data), 32'd3);
        tick();
        check("s4_done", 32'(b_if.out_valid), 32'd0);
        check("s4_idle", 32'(b_if.busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
